// File: rtl/sys_out_buf_ctrl_if.sv
// Bus between the sys_out address generator / systolic array, the buffer
// controller and the downstream LSTM stage. The master side produces the
// results and consumes the drained stream. The slave side is the controller.
interface sys_out_buf_ctrl_if #(
    parameter int FEATURE_BITS = 4,
    parameter int DATA_W       = 16
);
    localparam int AW = 2 * FEATURE_BITS;

    logic              start;
    logic              sys_valid;
    logic [DATA_W-1:0] sys_data;
    logic [AW-1:0]     wr_addr;
    logic              ag_done;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [AW-1:0]     out_addr;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, sys_valid, sys_data, wr_addr, ag_done, out_ready,
        input  out_valid, out_data, out_addr, busy, done, err
    );

    modport slave (
        input  start, sys_valid, sys_data, wr_addr, ag_done, out_ready,
        output out_valid, out_data, out_addr, busy, done, err
    );
endinterface

// File: rtl/sys_out_buf_ctrl.sv
// sys_out buffer controller: captures systolic-array results at generator-supplied
// addresses, then drains the buffer in linear order over a valid/ready stream.
// The drain path has a 1-cycle synchronous RAM read. One output register and one
// skid register hold the words. Reads are issued only when a landing slot is
// guaranteed, so backpressure never drops or duplicates a word.
module sys_out_buf_ctrl #(
    parameter int FEATURE_BITS = 4,
    parameter int DATA_W       = 16,
    parameter int NUM_WORDS    = 27
) (
    input logic               sys_clk,
    input logic               reset_n,
    sys_out_buf_ctrl_if.slave bus
);
    localparam int AW    = 2 * FEATURE_BITS;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = AW + 1;   // counters must be able to hold NUM_WORDS itself

    localparam logic [CW-1:0] LAST_CNT  = CW'(NUM_WORDS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;

    logic [CW-1:0]     wr_cnt;
    logic [CW-1:0]     rd_ptr;
    logic              rd_pending;
    logic [AW-1:0]     rd_pend_addr;

    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic [AW-1:0]     out_addr_reg;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [AW-1:0]     skid_addr;

    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;

    logic              wr_en;
    logic              xfer;
    logic              rd_en;
    logic [1:0]        occupancy;

    // Words held or in flight. A read may be issued only if at most one
    // word remains after this cycle's transfer, because output and skid hold two.
    assign wr_en     = (state == FILL) && bus.sys_valid && !bus.ag_done;
    assign xfer      = out_valid_reg && bus.out_ready;
    assign occupancy = {1'b0, out_valid_reg} + {1'b0, skid_valid} + {1'b0, rd_pending};
    assign rd_en     = (state == DRAIN) && (rd_ptr < LAST_CNT)
                       && ((occupancy - {1'b0, xfer}) <= 2'd1);

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_addr  = out_addr_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;

    // Buffer RAM: a single write port during FILL and a registered read port during DRAIN.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[bus.wr_addr] <= bus.sys_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_ptr[AW-1:0]];
        end
    end

    // Pass sequencing, counters, drain pipeline and registered status outputs.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            wr_cnt        <= '0;
            rd_ptr        <= '0;
            rd_pending    <= 1'b0;
            rd_pend_addr  <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_addr_reg  <= '0;
            skid_valid    <= 1'b0;
            skid_data     <= '0;
            skid_addr     <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state    <= FILL;
                        wr_cnt   <= '0;
                        rd_ptr   <= '0;
                        err_reg  <= 1'b0;
                        busy_reg <= 1'b1;
                        done_reg <= 1'b0;
                    end
                end

                FILL: begin
                    if (bus.ag_done) begin
                        if (wr_cnt != LAST_CNT) begin
                            err_reg <= 1'b1;
                        end
                        rd_ptr <= '0;
                        state  <= DRAIN;
                    end else if (wr_en && (wr_cnt != LAST_CNT)) begin
                        wr_cnt <= wr_cnt + CW'(1);
                    end
                end

                DRAIN: begin
                    rd_pending <= rd_en;
                    if (rd_en) begin
                        rd_ptr       <= rd_ptr + CW'(1);
                        rd_pend_addr <= rd_ptr[AW-1:0];
                    end

                    // The output slot frees on a transfer or when it is empty.
                    // The skid word is older than the word arriving from RAM.
                    if (xfer || !out_valid_reg) begin
                        if (skid_valid) begin
                            out_valid_reg <= 1'b1;
                            out_data_reg  <= skid_data;
                            out_addr_reg  <= skid_addr;
                            skid_valid    <= rd_pending;
                            skid_data     <= rd_data;
                            skid_addr     <= rd_pend_addr;
                        end else begin
                            out_valid_reg <= rd_pending;
                            if (rd_pending) begin
                                out_data_reg <= rd_data;
                                out_addr_reg <= rd_pend_addr;
                            end
                        end
                    end else if (rd_pending) begin
                        skid_valid <= 1'b1;
                        skid_data  <= rd_data;
                        skid_addr  <= rd_pend_addr;
                    end

                    // The last address is issued last, so nothing is queued behind it.
                    if (xfer && (out_addr_reg == LAST_ADDR)) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        state         <= DONE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sys_out_buf_ctrl.sv
// Self-checking bench for sys_out_buf_ctrl. A plain array models the buffer
// contents across passes and resets, and the expected stream is the array read in
// address order. Writes, data, gaps, readiness and ignored inputs are randomized.
module tb_sys_out_buf_ctrl;
    localparam int FB = 4;
    localparam int DW = 16;
    localparam int NW = 27;
    localparam int AW = 2 * FB;

    logic sys_clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 sys_clk = ~sys_clk;

    sys_out_buf_ctrl_if #(.FEATURE_BITS(FB), .DATA_W(DW)) bus ();

    sys_out_buf_ctrl #(
        .FEATURE_BITS(FB),
        .DATA_W      (DW),
        .NUM_WORDS   (NW)
    ) dut (
        .sys_clk(sys_clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    logic [DW-1:0] model_mem [NW];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One full pass. wmode selects the write pattern, nwr is the number of writes,
    // rmode selects out_ready (0 always, 1 = 1,0,0,1 pattern, 2 random),
    // abort_after > 0 resets mid-drain after that many transfers, and poke pulses
    // start during FILL/DRAIN.
    task automatic run_pass(input int wmode, input int nwr, input int rmode,
                            input int abort_after, input bit poke);
        int            a;
        logic [DW-1:0] d;
        int            idx;
        int            cyc;
        int            first_cyc;
        bit            held;
        bit            ready;
        bit            exp_err;
        logic [DW-1:0] hold_d;
        logic [AW-1:0] hold_a;

        @(negedge sys_clk);
        bus.start = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
        check("fill_busy", bus.busy, 1);
        check("fill_done", bus.done, 0);
        check("start_clears_err", bus.err, 0);

        for (int k = 0; k < nwr; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.sys_valid = 1'b0;
                bus.wr_addr   = AW'($urandom_range(0, NW - 1));
                bus.sys_data  = DW'($urandom);
                bus.start     = poke;
                @(negedge sys_clk);
                bus.start     = 1'b0;
            end
            case (wmode)
                0:       begin a = k;                        d = DW'(16'h100 + k); end
                1:       begin a = (k * 9) % 27;             d = DW'(k);           end
                2:       begin a = k;                        d = DW'($urandom);    end
                default: begin a = $urandom_range(0, NW - 1); d = DW'($urandom);   end
            endcase
            bus.sys_valid = 1'b1;
            bus.wr_addr   = AW'(a);
            bus.sys_data  = d;
            model_mem[a]  = d;
            @(negedge sys_clk);
        end

        // ag_done cycle with a live sys_valid that must not be written
        bus.sys_valid = 1'b1;
        bus.wr_addr   = AW'($urandom_range(0, NW - 1));
        bus.sys_data  = 16'hDEAD;
        bus.ag_done   = 1'b1;
        @(negedge sys_clk);
        bus.ag_done   = 1'b0;
        bus.sys_valid = 1'b0;
        exp_err = (nwr < NW);
        check("drain_err", bus.err, 32'(exp_err));
        check("drain_busy", bus.busy, 1);

        idx = 0;
        cyc = 0;
        first_cyc = -1;
        held = 1'b0;
        hold_d = '0;
        hold_a = '0;
        while (idx < NW && cyc < 400) begin
            if (held) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_data", bus.out_data, hold_d);
                check("stall_addr", bus.out_addr, hold_a);
            end
            if (rmode == 0 && first_cyc >= 0) begin
                check("no_bubble", bus.out_valid, 1);
            end
            bus.start = poke && ($urandom_range(0, 3) == 0);
            case (rmode)
                0:       ready = 1'b1;
                1:       ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = ready;
            if (bus.out_valid) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    check("first_valid_latency", 32'(first_cyc <= 2), 1);
                end
                if (ready) begin
                    $display("xfer addr=%0d data=0x%0h", bus.out_addr, bus.out_data);
                    check("out_addr", bus.out_addr, idx);
                    check("out_data", bus.out_data, model_mem[idx]);
                    idx++;
                end
            end
            held   = bus.out_valid && !ready;
            hold_d = bus.out_data;
            hold_a = bus.out_addr;
            @(negedge sys_clk);
            cyc++;
            if (abort_after > 0 && idx == abort_after) break;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;

        if (abort_after > 0) begin
            check("abort_count", idx, abort_after);
            reset_n = 1'b0;
            #1;
            check("abort_valid", bus.out_valid, 0);
            check("abort_busy", bus.busy, 0);
            check("abort_done", bus.done, 0);
            check("abort_err", bus.err, 0);
            @(negedge sys_clk);
            @(negedge sys_clk);
            reset_n = 1'b1;
            @(negedge sys_clk);
            check("abort_idle_busy", bus.busy, 0);
            check("abort_idle_valid", bus.out_valid, 0);
        end else begin
            check("drain_count", idx, NW);
            check("end_valid", bus.out_valid, 0);
            check("end_done", bus.done, 1);
            check("end_busy", bus.busy, 0);
            check("end_err", bus.err, 32'(exp_err));
        end
    endtask

    // sys_valid in IDLE/DONE must not write. Addresses avoid 0/9/18 so a later
    // permuted pass exposes any stray write.
    task automatic stray_writes(input int n, input bit exp_done);
        int a;
        for (int i = 0; i < n; i++) begin
            a = $urandom_range(1, NW - 1);
            if ((a % 9) == 0) a++;
            bus.sys_valid = 1'b1;
            bus.wr_addr   = AW'(a);
            bus.sys_data  = DW'($urandom);
            @(negedge sys_clk);
            check("stray_done", bus.done, 32'(exp_done));
            check("stray_busy", bus.busy, 0);
        end
        bus.sys_valid = 1'b0;
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.sys_valid = 1'b0;
        bus.sys_data  = '0;
        bus.wr_addr   = '0;
        bus.ag_done   = 1'b0;
        bus.out_ready = 1'b0;
        reset_n       = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_addr", bus.out_addr, 0);
        reset_n = 1'b1;
        @(negedge sys_clk);
        check("idle_busy", bus.busy, 0);

        run_pass(0, NW, 0, 0, 1'b0);   // basic
        stray_writes(4, 1'b1);         // ignored in DONE
        run_pass(1, NW, 1, 0, 1'b1);   // permuted, 1,0,0,1 backpressure, start pokes
        run_pass(2, 20, 2, 0, 1'b0);   // short pass -> err
        run_pass(3, NW, 2, 10, 1'b0);  // reset after 10 transfers
        stray_writes(4, 1'b0);         // ignored in IDLE
        run_pass(1, NW, 0, 0, 1'b0);   // permuted, exposes stray writes
        run_pass(0, NW, 0, 0, 1'b0);   // basic again after reset
        run_pass(3, NW, 2, 0, 1'b1);   // random everything

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
